// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised multi-port general-purpose register file with
//            same-cycle write-to-read forwarding, a per-register pending-write
//            scoreboard for decode hazard stalls, and a sequenced bulk-clear
//            engine that zeroes storage after reset or on request.
// Ports    : clk        - clock, all state updates on rising edge
//            rst        - asynchronous active-low reset
//            rd_en      - per-read-port enable                [NRD]
//            rd_addr    - read addresses, port i at [i*ADDR_W +: ADDR_W]
//            rd_data    - combinational read data, port i at [i*DATA_W +: DATA_W]
//            rd_busy    - per-read-port outstanding-producer flag
//            wr_en      - per-write-port enable               [NWR]
//            wr_addr    - write addresses
//            wr_data    - write data
//            resv_en    - reserve a destination register
//            resv_addr  - register to mark pending
//            clr_req    - request bulk clear of storage and scoreboard
//            ready      - registered; 1 = operational, 0 = clearing/in reset
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 32,
  parameter  int NRD    = 2,
  parameter  int NWR    = 1,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD-1:0]          rd_en,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_busy,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR*ADDR_W-1:0]   wr_addr,
  input  logic [NWR*DATA_W-1:0]   wr_data,
  input  logic                    resv_en,
  input  logic [ADDR_W-1:0]       resv_addr,
  input  logic                    clr_req,
  output logic                    ready
);

  localparam logic [ADDR_W-1:0] C_LAST_REG  = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] C_FIRST_REG = ADDR_W'(1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t                state, state_nx;
  logic [ADDR_W-1:0]     clr_cnt, clr_cnt_nx;
  logic                  ready_nx;
  logic                  sb_clear;

  logic [DATA_W-1:0]     regs [NREGS];
  logic [NREGS-1:0]      pending, pending_nx;

  logic [ADDR_W-1:0]     rd_a   [NRD];
  logic [ADDR_W-1:0]     wr_a   [NWR];
  logic [DATA_W-1:0]     wr_d   [NWR];
  logic [NWR-1:0]        wr_act;

  logic [DATA_W-1:0]     rd_val;
  logic                  fwd_hit;

  // Unpack the flat port buses and qualify writes. Writes only take effect
  // while operational, and r0 is never a real destination.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_a[i] = rd_addr[i*ADDR_W +: ADDR_W];
    end
    for (int j = 0; j < NWR; j++) begin
      wr_a[j]   = wr_addr[j*ADDR_W +: ADDR_W];
      wr_d[j]   = wr_data[j*DATA_W +: DATA_W];
      wr_act[j] = ready & wr_en[j] & (wr_a[j] != '0);
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM: CLEAR walks r1..r(NREGS-1), READY serves the pipeline.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_CLEAR;
      clr_cnt <= C_FIRST_REG;
      ready   <= 1'b0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_cnt_nx;
      ready   <= ready_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    ready_nx   = ready;
    sb_clear   = 1'b0;
    case (state)
      S_CLEAR: begin
        clr_cnt_nx = clr_cnt + 1'b1;
        if (clr_cnt == C_LAST_REG) begin
          state_nx = S_READY;
          ready_nx = 1'b1;
        end
      end
      S_READY: begin
        if (clr_req) begin
          state_nx   = S_CLEAR;
          clr_cnt_nx = C_FIRST_REG;
          ready_nx   = 1'b0;
          sb_clear   = 1'b1;
        end
      end
      default: begin
        state_nx   = S_CLEAR;
        clr_cnt_nx = C_FIRST_REG;
        ready_nx   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Storage. No reset: contents are only observable once the clear sweep has
  // zeroed them. Later write ports override earlier ones on the same address.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!ready) begin
      regs[clr_cnt] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_act[j]) begin
          regs[wr_a[j]] <= wr_d[j];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pending-write scoreboard. Completing writes clear, then a new reservation
  // sets, so a reservation colliding with a write to the same register wins.
  // --------------------------------------------------------------------------
  always_comb begin
    pending_nx = pending;
    for (int j = 0; j < NWR; j++) begin
      if (wr_act[j]) begin
        pending_nx[wr_a[j]] = 1'b0;
      end
    end
    if (resv_en) begin
      pending_nx[resv_addr] = 1'b1;
    end
    pending_nx[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else if (sb_clear) begin
      pending <= '0;
    end else if (ready) begin
      pending <= pending_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports. A same-cycle write supplies the value (highest port wins) and
  // also hides the pending bit, since the producer is completing right now.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_val  = '0;
    fwd_hit = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      rd_val  = '0;
      fwd_hit = 1'b0;
      if (ready && rd_en[i] && (rd_a[i] != '0)) begin
        rd_val = regs[rd_a[i]];
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wr_a[j] == rd_a[i])) begin
            rd_val  = wr_d[j];
            fwd_hit = 1'b1;
          end
        end
        rd_busy[i] = pending[rd_a[i]] & ~fwd_hit;
      end
      rd_data[i*DATA_W +: DATA_W] = rd_val;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Self-checking bench for regfile_mp (2 read ports, 2 write ports).
//            Stimulus pushes predicted outputs into a queue; a monitor pops
//            and compares on the falling edge of every cycle.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              resv_en;
  logic [AW-1:0]     resv_addr;
  logic              clr_req;
  logic              ready;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .resv_en(resv_en), .resv_addr(resv_addr),
    .clr_req(clr_req), .ready(ready)
  );

  // Reference model: architectural register values, pending flags, and the
  // number of edges left before the file becomes operational again.
  logic [DW-1:0] m_reg  [NR];
  bit            m_pend [NR];
  bit            m_ready;
  int            clr_left;

  typedef struct {
    logic [NRD*DW-1:0] data;
    logic [NRD-1:0]    busy;
    logic              rdy;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Any clear (reset or request) leaves every register zero once ready returns,
  // and reads are masked until then, so zero the model up front.
  task automatic start_clear();
    m_ready  = 1'b0;
    clr_left = NR - 1;
    for (int r = 0; r < NR; r++) begin
      m_reg[r]  = '0;
      m_pend[r] = 1'b0;
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.data = '0;
    e.busy = '0;
    e.rdy  = m_ready;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a = rd_addr[i*AW +: AW];
      logic [DW-1:0] v = '0;
      bit            w = 1'b0;
      if (m_ready && rd_en[i] && a != 0) begin
        v = m_reg[a];
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
            v = wr_data[j*DW +: DW];
            w = 1'b1;
          end
        end
        e.busy[i] = m_pend[a] && !w;
      end
      e.data[i*DW +: DW] = v;
    end
    return e;
  endfunction

  task automatic model_edge();
    if (rst == 1'b0) return;
    if (!m_ready) begin
      clr_left--;
      if (clr_left == 0) m_ready = 1'b1;
    end else if (clr_req) begin
      start_clear();
    end else begin
      for (int j = 0; j < NWR; j++) begin
        logic [AW-1:0] a = wr_addr[j*AW +: AW];
        if (wr_en[j] && a != 0) begin
          m_reg[a]  = wr_data[j*DW +: DW];
          m_pend[a] = 1'b0;
        end
      end
      if (resv_en && resv_addr != 0) m_pend[resv_addr] = 1'b1;
    end
  endtask

  // One cycle: predict this cycle's outputs, then advance the model at the edge.
  task automatic step();
    q.push_back(predict());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    resv_en = 1'b0; resv_addr = '0; clr_req = 1'b0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = a[AW-1:0];
  endtask

  task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a[AW-1:0];
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic read_all();
    for (int a = 0; a < NR; a++) begin
      idle();
      set_rd(0, a);
      set_rd(1, NR - 1 - a);
      step();
    end
  endtask

  task automatic run_clear_window();
    for (int k = 0; k < NR + 1; k++) begin
      idle();
      rd_en   = NRD'($urandom);
      rd_addr = (NRD*AW)'($urandom);
      set_wr(0, 3, 32'h77);
      resv_en = 1'b1; resv_addr = 5'd4;
      clr_req = 1'($urandom);
      step();
    end
  endtask

  // Monitor: compares whatever the stimulus predicted for this cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        check("ready",    64'(ready),             64'(mon_e.rdy));
        check("rd_data0", 64'(rd_data[DW-1:0]),   64'(mon_e.data[DW-1:0]));
        check("rd_data1", 64'(rd_data[2*DW-1:DW]),64'(mon_e.data[2*DW-1:DW]));
        check("rd_busy",  64'(rd_busy),           64'(mon_e.busy));
      end
    end
  end

  initial begin
    rst = 1'b0;
    idle();
    start_clear();
    @(posedge clk); #1;

    // Reset release and initial clear sweep.
    repeat (3) step();
    rst = 1'b1;
    for (int k = 0; k < NR + 1; k++) begin
      idle();
      rd_en   = 2'b11;
      rd_addr = (NRD*AW)'($urandom);
      set_wr(0, 6, 32'hBAD);
      step();
    end
    read_all();

    // Forwarding and r0.
    idle(); set_wr(0, 5, 32'hDEAD_BEEF); set_rd(0, 5); set_rd(1, 0); step();
    idle(); set_rd(0, 5); step();

    // Dual-write collision.
    idle(); set_wr(0, 7, 32'h1111); set_wr(1, 7, 32'h2222); set_rd(0, 7); set_rd(1, 7); step();
    idle(); set_rd(0, 7); step();

    // Scoreboard.
    idle(); resv_en = 1'b1; resv_addr = 5'd9; set_rd(0, 9); step();
    idle(); set_rd(0, 9); set_rd(1, 9); step();
    idle(); set_rd(0, 9); step();
    idle(); set_wr(0, 9, 32'h55); set_rd(0, 9); step();
    idle(); set_rd(0, 9); step();
    idle(); resv_en = 1'b1; resv_addr = 5'd9; set_wr(1, 9, 32'h66); set_rd(1, 9); step();
    idle(); set_rd(0, 9); set_rd(1, 9); step();

    // Clear request with writes attempted while clearing.
    idle(); set_wr(0, 3, 32'hA5); step();
    idle(); resv_en = 1'b1; resv_addr = 5'd3; set_rd(0, 3); step();
    idle(); clr_req = 1'b1; set_rd(0, 3); set_rd(1, 9); step();
    run_clear_window();
    idle(); set_rd(0, 3); set_rd(1, 4); step();

    // Reset in the middle of a clear sweep (counter at 10).
    idle(); clr_req = 1'b1; step();
    idle(); repeat (9) step();
    rst = 1'b0; start_clear();
    idle(); repeat (2) step();
    rst = 1'b1;
    for (int k = 0; k < NR + 1; k++) begin
      idle(); set_rd(0, k % NR); step();
    end
    read_all();

    // Randomised traffic on a small address window to provoke collisions.
    for (int k = 0; k < 700; k++) begin
      idle();
      rd_en = NRD'($urandom);
      for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, 9));
      wr_en = NWR'($urandom);
      for (int j = 0; j < NWR; j++) begin
        wr_addr[j*AW +: AW] = AW'($urandom_range(0, 9));
        wr_data[j*DW +: DW] = $urandom;
      end
      resv_en   = ($urandom_range(0, 3) == 0);
      resv_addr = AW'($urandom_range(0, 9));
      clr_req   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        start_clear();
        step();
        rst = 1'b1;
      end else begin
        step();
      end
    end

    idle();
    @(negedge clk); #1;
    check("drain", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the MIPS core. It is the successor to the single-write, two-read register file.
- Configurable data width, register count, number of read ports and number of write ports.
- Same-cycle write-to-read forwarding.
- Per-register pending-write scoreboard that decode uses for hazard stalls.
- Sequenced bulk-clear engine that zeroes storage after reset or on request.

Parameters:
DATA_W, 32, register data width in bits.
NREGS, 32, number of registers; power of two, at least 4; register 0 is hard-wired zero.
NRD, 2, number of read ports, 1..4.
NWR, 1, number of write ports, 1..2.
ADDR_W, $clog2(NREGS), register address width; derived, not overridden.

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst  in  1  asynchronous, active-low reset (rst==0 asserts).
rd_en  in  NRD  per-read-port enable.
rd_addr  in  NRD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
rd_data  out  NRD*DATA_W  read data, combinational.
rd_busy  out  NRD  1 = register read on port i has an outstanding producer.
wr_en  in  NWR  per-write-port enable (writeback stage).
wr_addr  in  NWR*ADDR_W  write addresses.
wr_data  in  NWR*DATA_W  write data.
resv_en  in  1  reserve destination register (issue of a writing instruction).
resv_addr  in  ADDR_W  register to mark pending.
clr_req  in  1  request a bulk clear of storage and scoreboard.
ready  out  1  registered; 1 = file operational, 0 = clearing or in reset.

Behaviour:
- Reset, asynchronous on rst==0:
  - state=CLEAR, clear counter=1, ready=0.
  - All scoreboard bits 0.
  - Storage contents undefined until CLEAR completes.
- State machine, two states:
  - CLEAR: each cycle writes 0 to regs[counter] and increments counter. After writing NREGS-1, go to READY and ready<=1 on that edge. ready rises exactly NREGS-1 rising edges after rst deasserts (31 for defaults).
  - READY: when clr_req==1 at an edge, go to CLEAR, counter<=1, ready<=0, and all scoreboard bits cleared. clr_req is ignored during CLEAR.
- While ready==0:
  - wr_en and resv_en are ignored.
  - rd_data=0 and rd_busy=0 on all ports.
- Reads, combinational, per port i, in priority order:
  1. ready==0, or rd_addr==0, or rd_en==0 gives rd_data=0.
  2. Else if any write port j has wr_en and wr_addr==rd_addr, rd_data=wr_data of the highest-index matching port (forwarding).
  3. Else rd_data=regs[rd_addr].
- Writes, at the rising edge when ready==1:
  - Each write port with wr_en and wr_addr!=0 updates storage.
  - If two ports target the same address, the higher-index port wins.
  - Writes to address 0 are discarded.
- Scoreboard, one pending bit per register; bit 0 is constant 0:
  - A write from any port to register r clears pending[r].
  - resv_en with resv_addr=r (r!=0) sets pending[r].
  - If a set and a clear hit the same r in one cycle, the set wins (newer producer).
- rd_busy[i] = ready & rd_en[i] & pending[rd_addr[i]] & no write port currently writing rd_addr[i]. A same-cycle forwarded value is not reported busy.
- Reset asserted mid-CLEAR or mid-operation aborts immediately and restarts CLEAR from counter=1 after deassert.
- No combinational path from any input to ready.

Test Plan:
- Reset release: hold rst=0 for 3 cycles, then rst=1. Required: ready=0 for exactly 31 edges, then ready=1. Every register then reads 0 on both ports.
- Forwarding and r0: wr_en=1, wr_addr=5, wr_data=32'hDEAD_BEEF; same cycle read port 0 addr 5 and port 1 addr 0. Required: rd_data0=DEAD_BEEF, rd_data1=0. Next cycle port 0 still reads DEAD_BEEF with wr_en=0.
- Dual-write collision (NWR=2): port0 writes r7=32'h1111, port1 writes r7=32'h2222 in the same cycle. Required: forwarded value is 2222; stored value after the edge is 2222.
- Scoreboard: resv r9, then read r9. Required: rd_busy=1 on the following cycles. Write r9 with 32'h55 and read r9 in the same cycle: rd_busy=0, rd_data=55. In a cycle with resv r9 and write r9 together, the bit stays set (rd_busy=1 next cycle).
- clr_req in READY: write r3=32'hA5, pulse clr_req. Required: ready falls next edge, all rd_busy=0, ready returns after 31 edges, r3 reads 0. Writes issued during CLEAR have no effect.
- Reset mid-clear: assert rst=0 at clear counter=10, release. Required: ready stays 0 for a full 31 edges from release, then all registers read 0.
